// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receive path
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // "release" is a reserved word, so the break flag is carried as rel
    typedef struct packed {
        logic       extended;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word fall-through queue of decoded scan events
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  ps2_event_t push_data_i,
    input  logic       pop_i,
    output ps2_event_t head_o,
    output logic       valid_o,
    output logic       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ps2_event_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the head slot, so a full queue still accepts
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_q + CW'(do_push) - CW'(do_pop);
            overflow_q <= push_i && !do_push;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o    = !empty;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_rx_stream.sv
// rtl/ps2_rx_stream.sv - PS/2 device-to-host receiver with prefix folding and event queue
module ps2_rx_stream
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       extended_o,
    output logic       release_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overflow_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic       clk_s1_q;
    logic       clk_s2_q;
    logic       data_s1_q;
    logic       data_s2_q;
    logic       filt_clk_q;
    logic [3:0] filt_cnt_q;
    logic       sample;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          ext_q;
    logic          rel_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          push_q;
    ps2_event_t    push_ev_q;
    logic          parity_err_q;
    logic          frame_err_q;

    ps2_event_t head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data_i;
            data_s2_q <= data_s1_q;
            if (clk_s2_q != filt_clk_q) begin
                if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
                    filt_clk_q <= clk_s2_q;
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 4'd1;
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    // Falling edge of the filtered clock, seen in the cycle it is about to toggle
    assign sample = filt_clk_q && !clk_s2_q && (filt_cnt_q == 4'(FILTER_LEN - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            push_q       <= 1'b0;
            push_ev_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (sample || state_q == ST_IDLE) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end

            if (sample) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= data_s2_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (!data_s2_q) begin
                            frame_err_q <= 1'b1;
                            ext_q       <= 1'b0;
                            rel_q       <= 1'b0;
                        end else if (!odd_parity_ok(shift_q, par_q)) begin
                            parity_err_q <= 1'b1;
                            ext_q        <= 1'b0;
                            rel_q        <= 1'b0;
                        end else if (shift_q == PS2_EXT) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            rel_q <= 1'b1;
                        end else begin
                            push_q    <= 1'b1;
                            push_ev_q <= {ext_q, rel_q, shift_q};
                            ext_q     <= 1'b0;
                            rel_q     <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE && tmo_cnt_q == TW'(TIMEOUT_CYCLES)) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
                ext_q       <= 1'b0;
                rel_q       <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push_q),
        .push_data_i(push_ev_q),
        .pop_i      (ready_i),
        .head_o     (head),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    assign code_o       = head.code;
    assign extended_o   = head.extended;
    assign release_o    = head.rel;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_stream.sv
// tb/tb_ps2_rx_stream.sv - directed self-checking bench for ps2_rx_stream
module tb_ps2_rx_stream;

    localparam int FL = 4;
    localparam int TO = 2000;
    localparam int FD = 4;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ready;
    logic [7:0] code;
    logic       extended;
    logic       rel;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovf;

    logic [9:0] got[$];
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovf  = 0;
    int checks = 0;
    int errors = 0;
    int b_perr;
    int b_ferr;

    always #5 clk = ~clk;

    ps2_rx_stream #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .code_o      (code),
        .extended_o  (extended),
        .release_o   (rel),
        .valid_o     (valid),
        .ready_i     (ready),
        .parity_err_o(perr),
        .frame_err_o (ferr),
        .overflow_o  (ovf)
    );

    always @(negedge clk) begin
        if (valid && ready) got.push_back({extended, rel, code});
        if (perr) n_perr++;
        if (ferr) n_ferr++;
        if (ovf)  n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input logic pop_at_stop, input logic glitch);
        ps2_data = b;
        if (glitch) begin
            step(H / 2);
            ps2_clk = 1'b0;
            step(FL - 2);
            ps2_clk = 1'b1;
            step(H - H / 2 - (FL - 2));
        end else begin
            step(H);
        end
        ps2_clk = 1'b0;
        if (pop_at_stop) begin
            // land the single pop on the cycle the stop-bit event is pushed
            step(6);
            ready = 1'b1;
            step(1);
            ready = 1'b0;
            step(H - 7);
        end else begin
            step(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                              input logic pop_at_stop, input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(f[i], pop_at_stop && (i == 10), i == glitch_bit);
        end
        ps2_data = 1'b1;
        step(2 * H);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0, -1);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ready    = 1'b0;
        step(5);
        rst_n = 1'b1;
        step(2);
        check("rst_valid", valid, 0);
        check("rst_code", code, 0);
        check("rst_ext_rel", {extended, rel}, 0);
        check("rst_pulses", {perr, ferr, ovf}, 0);

        ready = 1'b1;
        send(8'h1C);
        check("t1_count", got.size(), 1);
        check("t1_ev", got[0], 10'h01C);
        check("t1_errs", n_perr + n_ferr + n_ovf, 0);

        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_count", got.size(), 3);
        check("t2_ev_brk", got[1], 10'h11C);
        check("t2_ev_ext_brk", got[2], 10'h375);

        b_perr = n_perr;
        send(8'hF0);
        send_frame(8'h1C, 1'b1, 11, 1'b0, -1);
        check("t3_perr", n_perr - b_perr, 1);
        check("t3_no_event", got.size(), 3);
        send(8'hE0); send(8'h75);
        check("t3_ev", got[3], 10'h275);
        check("t3_ferr", n_ferr, 0);

        b_ferr = n_ferr;
        send(8'hE0);
        send_frame(8'h1C, 1'b0, 5, 1'b0, -1);
        step(TO + 10);
        check("t4_ferr", n_ferr - b_ferr, 1);
        send(8'h1C);
        check("t4_ev", got[4], 10'h01C);
        check("t4_count", got.size(), 5);

        ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t5_no_ovf", n_ovf, 0);
        send(8'h05);
        check("t5_ovf", n_ovf, 1);
        check("t5_head_hold", {valid, code}, 9'h101);
        send_frame(8'h06, 1'b0, 11, 1'b1, -1);
        check("t5_pushpop_no_ovf", n_ovf, 1);
        check("t5_popped", got.size(), 6);
        ready = 1'b1;
        step(10);
        check("t5_count", got.size(), 10);
        check("t5_ev0", got[5], 10'h001);
        check("t5_ev1", got[6], 10'h002);
        check("t5_ev2", got[7], 10'h003);
        check("t5_ev3", got[8], 10'h004);
        check("t5_ev4", got[9], 10'h006);
        check("t5_empty", valid, 0);

        b_perr = n_perr;
        b_ferr = n_ferr;
        ps2_clk = 1'b0;
        step(FL - 2);
        ps2_clk = 1'b1;
        step(H);
        send_frame(8'h1C, 1'b0, 11, 1'b0, 4);
        check("t6_count", got.size(), 11);
        check("t6_ev", got[10], 10'h01C);
        check("t6_errs", (n_perr - b_perr) + (n_ferr - b_ferr), 0);

        ready = 1'b0;
        send(8'hE0); send(8'h7A);
        check("t7_pre_valid", {valid, extended, rel, code}, 11'h67A);
        send(8'hF0);
        send_frame(8'h1C, 1'b0, 4, 1'b0, -1);
        #3;
        rst_n = 1'b0;
        #2;
        check("t7_rst_valid", valid, 0);
        check("t7_rst_outs", {extended, rel, code}, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(2);
        ready = 1'b1;
        send(8'h1C);
        check("t7_count", got.size(), 12);
        check("t7_ev", got[11], 10'h01C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_stream.md
Name: ps2_rx_stream

Overview:
Parametrised PS/2 device-to-host receiver running on the system clock. It oversamples the PS/2 clock and data lines, deglitches them, and checks start, odd-parity and stop bits. It also recovers from stalled frames and folds the E0 (extended) and F0 (break) prefixes into a single scan event. Events are buffered in a small FIFO behind a valid/ready interface for the keyboard/console logic.

Parameters:
FILTER_LEN, 4, consecutive identical samples needed before filtered ps2_clk changes level (1..15)
TIMEOUT_CYCLES, 100000, system cycles without a falling edge before an in-progress frame is abandoned
FIFO_DEPTH, 4, scan events buffered (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock line (asynchronous)
ps2_data  in  1  raw PS/2 data line (asynchronous)
code  out  8  scan code of head event
extended  out  1  head event was preceded by E0
release  out  1  head event was preceded by F0 (break)
valid  out  1  head event available
ready  in  1  consumer accepts head event when valid&&ready
parity_err  out  1  one-cycle pulse: parity check failed
frame_err  out  1  one-cycle pulse: bad stop bit or timeout
overflow  out  1  one-cycle pulse: event dropped, FIFO full

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, prefix flags clear, filtered clk=1, all outputs 0 (code/extended/release read 0).
- Input path: 2-FF synchronisers on ps2_clk and ps2_data.
  - Filtered clk toggles only after FILTER_LEN consecutive synchronised samples differ from its current level.
  - Sample event = filtered clk 1->0; synchronised data is captured in that same cycle.
- FSM (advances only on sample events, except timeout):
  - IDLE: data=0 -> DATA, bit_cnt=0; data=1 -> stay in IDLE (spurious edge ignored, no error).
  - DATA: shift in LSB first; after 8th bit -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP: data=1 and XOR(8 data bits, parity)=1 -> byte good. data=0 -> frame_err. Parity bad with stop good -> parity_err. Both bad -> frame_err only. Always -> IDLE.
- Timeout: idle counter clears on every sample event. In any state other than IDLE, when it reaches TIMEOUT_CYCLES: -> IDLE, pulse frame_err, clear prefix flags.
- Prefix fold, on a good byte:
  - 0xE0 sets ext flag; 0xF0 sets rel flag; neither is pushed.
  - Any other byte pushes {ext, rel, byte} and clears both flags.
  - Any parity_err or frame_err also clears both flags.
- Latency: push happens in the cycle after the STOP sample event; valid is high on the next cycle (2 clk after the stop edge is detected).
- FIFO is first-word fall-through: code, extended and release reflect the head while valid=1 and hold steady until popped.
- Full FIFO with a push and no pop in the same cycle: event dropped, overflow pulses, FIFO contents unchanged.
- Full FIFO with a push and a pop in the same cycle: both succeed, no overflow.
- Empty FIFO: ready is ignored.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Reset mid-frame: partial frame discarded; the next frame decodes normally from IDLE.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Packed struct ps2_event_t {extended, release, code[7:0]}.
- Sub-module ps2_event_fifo (parametrised FIFO of ps2_event_t, FWFT, with a full/empty handshake).
- Synchroniser, filter, FSM and prefix logic stay in the top module.

Test Plan:
- Frame for 0x1C (serial order 0, 0,0,1,1,1,0,0,0, parity 0, stop 1), ~12 kHz PS/2 clock, ready=1 -> one event code=0x1C, extended=0, release=0, no error pulses.
- Sequence F0,1C then E0,F0,75 -> two events: {0,1,0x1C}, then {1,1,0x75}; prefixes themselves never appear on the output.
- 0x1C frame sent with parity bit 1 -> parity_err pulses once, no event. The following E0,75 must decode as {1,0,0x75}, which proves no stale flag from the bad frame.
- Stall ps2_clk high after 5 bits for TIMEOUT_CYCLES+10 -> frame_err pulses once, FSM back in IDLE; the next 0x1C frame decodes correctly.
- FIFO_DEPTH=4, ready=0, send codes 0x01..0x05 -> overflow pulses on 0x05. Then ready=1 pops exactly 0x01,0x02,0x03,0x04 in order; a push and pop landing in the same cycle while full produce no overflow.
- Glitch: a ps2_clk low pulse of FILTER_LEN-2 clk inside IDLE and mid-frame -> no sample event, and the frame still decodes. Asserting rst_n=0 mid-frame clears valid and all outputs asynchronously.
